hilbert_sequencer: RTL and testbench

HILBERT_SEQUENCER -- requirements
Module: hilbert_sequencer

---
 rtl/hilbert_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_hilbert_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_sequencer.sv
// hilbert_sequencer: sequences an acquisition block for a Hilbert stage.
// A free-running tick counter produces the frame strobe. The FSM runs
// IDLE -> ARM -> LOCK -> RUN -> DRAIN and counts the frames completed in RUN.
// Optional build macro: HILBERT_SEQ_TIMEOUT_EN. When it is defined, LOCK gives
// up after 4 strobes without locked_i.
module hilbert_sequencer #(
  parameter int TICKS = 12,
  parameter int TBITS = 4,
  parameter int CBITS = 10,
  parameter int DELAY = 3
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CBITS-1:0] frames_i,
  input  logic             locked_i,
  output logic             enable_o,
  output logic             strobe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CBITS-1:0] count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_LOCK  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [TBITS-1:0] TICK_LAST = TBITS'(TICKS - 1);

  logic [TBITS-1:0] tick_q, tick_d;
  logic [2:0]       state_q, state_d;
  logic [CBITS-1:0] frames_q, frames_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             strobe;
  logic             lock_timeout;
  logic [CBITS-1:0] count_inc;

  // DELAY only shapes simulation timing in the original model. Synthesizable
  // logic has no delays, so the parameter is accepted and deliberately left
  // unused.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  assign strobe    = (tick_q == TICK_LAST);
  // Frames are counted modulo 2^CBITS. A latched frames value of 0 therefore
  // means a full wrap: the terminal strobe takes the count back to 0.
  assign count_inc = count_q + 1'b1;

  // The tick counter wraps at TICKS-1 in every state.
  always_comb begin
    tick_d = strobe ? '0 : tick_q + 1'b1;
  end

`ifdef HILBERT_SEQ_TIMEOUT_EN
  logic [1:0] lock_wait_q, lock_wait_d;

  // Count the strobes seen while LOCK waits for locked_i.
  always_comb begin
    lock_wait_d = lock_wait_q;
    if (state_q != S_LOCK) begin
      lock_wait_d = '0;
    end else if (strobe) begin
      lock_wait_d = lock_wait_q + 1'b1;
    end
  end

  // Strobe counter used for the lock timeout.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lock_wait_q <= '0;
    end else begin
      lock_wait_q <= lock_wait_d;
    end
  end

  // The timeout fires on the fourth strobe spent in LOCK.
  assign lock_timeout = (state_q == S_LOCK) && strobe && (lock_wait_q == 2'd3);
`else
  assign lock_timeout = 1'b0;
`endif

  // Next-state and datapath decisions of the sequencer FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    frames_d = frames_q;
    count_d  = count_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start_i wins over abort_i here because abort_i is not looked at.
        if (start_i) begin
          frames_d = frames_i;
          count_d  = '0;
          error_d  = 1'b0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        if (abort_i) begin
          error_d = 1'b1;
          state_d = S_DRAIN;
        end else if (strobe) begin
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (abort_i) begin
          error_d = 1'b1;
          state_d = S_DRAIN;
        end else if (locked_i) begin
          state_d = S_RUN;
        end else if (lock_timeout) begin
          error_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_RUN: begin
        // The frame still counts when an abort lands on its strobe.
        if (strobe) begin
          count_d = count_inc;
        end
        if (abort_i || !locked_i) begin
          error_d = 1'b1;
          state_d = S_DRAIN;
        end else if (strobe && (count_inc == frames_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!locked_i) begin
          done_d  = !error_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // enable_o is registered from the next state, so it changes only on
    // clock edges.
    enable_d = (state_d == S_ARM) || (state_d == S_LOCK) || (state_d == S_RUN);
  end

  // State registers. Asynchronous reset drops enable_o immediately.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of evaluation order.
    if (!reset_ni) begin
      tick_q   <= '0;
      state_q  <= S_IDLE;
      frames_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      state_q  <= state_d;
      frames_q <= frames_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign enable_o = enable_q;
  assign strobe_o = strobe;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign error_o  = error_q;
  assign count_o  = count_q;

endmodule

// File: tb/tb_hilbert_sequencer.sv
// Self-checking bench for hilbert_sequencer. The expected outputs come from a
// timeline model. The bench knows the cycle index since reset, so it can place
// every strobe, state change and output edge with plain arithmetic.
// Define HILBERT_SEQ_TIMEOUT_EN for both the bench and the RTL to cover the
// timeout build.
module tb_hilbert_sequencer;
  localparam int TICKS = 12;
  localparam int CBITS = 10;
  localparam int FULL  = 1 << CBITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             locked = 1'b0;
  logic [CBITS-1:0] frames = '0;
  logic             enable, strobe, busy, done, error;
  logic [CBITS-1:0] count;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  hilbert_sequencer #(
    .TICKS(TICKS), .TBITS(4), .CBITS(CBITS), .DELAY(3)
  ) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .start_i (start),
    .abort_i (abort),
    .frames_i(frames),
    .locked_i(locked),
    .enable_o(enable),
    .strobe_o(strobe),
    .busy_o  (busy),
    .done_o  (done),
    .error_o (error),
    .count_o (count)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release. It is the model's view of the tick
  // counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // First cycle at or after c on which the strobe is due.
  function automatic int next_strobe(input int c);
    return c + (TICKS - 1 - (c % TICKS));
  endfunction

  // Number of strobe cycles in [lo, hi].
  function automatic int strobes_in(input int lo, input int hi);
    if (hi < lo) return 0;
    return (hi + 1) / TICKS - lo / TICKS;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({enable, strobe, busy, done, error, count} !== '0) begin
      n_err++;
      $display("FAIL reset_state got en/stb/busy/done/err=%b%b%b%b%b count=%0d expected all 0",
               enable, strobe, busy, done, error, count);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (strobe !== ((k == 11) || (k == 23) || (k == 35))) begin
        n_err++;
        $display("FAIL strobe_timing cycle=%0d got %b expected %b", k, strobe, !strobe);
      end
      @(negedge clk);
    end
  endtask

  // mode 0: normal completion, 1: abort in RUN at count abort_k,
  // 2: abort on the terminal strobe, 3: locked_i drops in RUN at count abort_k.
  task automatic test_block(input string name, input int frames_v, input int lock_lag,
                            input int mode, input int abort_k, input bit abort_with_start);
    int c0, a, l, r1, rk, total, x, end_run, d, last_lock, cnt_exp, hi;
    bit aborted, drain_abort, stray_start, err_exp;
    logic [3:0] got, exp;
    c0    = cyc;
    total = (frames_v == 0) ? FULL : frames_v;
    a     = next_strobe(c0 + 1);
    l     = a + 1 + lock_lag;
    r1    = next_strobe(l + 1);
    rk    = r1 + TICKS * (total - 1);
    x     = -1;
    if (mode == 1 || mode == 3)
      x = r1 + TICKS * (abort_k - 1) + 1 + int'($urandom_range(0, TICKS - 2));
    else if (mode == 2)
      x = rk;
    end_run     = (mode == 0) ? rk : x;
    aborted     = (mode != 0);
    d           = (mode == 3) ? x + 1 : end_run + 1 + int'($urandom_range(0, 15));
    last_lock   = (mode == 3) ? x - 1 : d - 1;
    drain_abort = (mode == 0) && ($urandom_range(0, 1) == 1);
    stray_start = ($urandom_range(0, 1) == 1);
    for (int c = c0; c <= d + 3; c++) begin
      exp = {(c >= c0 + 1) && (c <= d), (c >= c0 + 1) && (c <= end_run),
             !aborted && (c == d + 1), (c % TICKS) == TICKS - 1};
      got = {busy, enable, done, strobe};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s ctl cyc=%0d busy/en/done/stb got %b expected %b", name, c, got, exp);
      end
      if (c > c0) begin
        hi      = (c - 1 < end_run) ? c - 1 : end_run;
        cnt_exp = (c <= l) ? 0 : strobes_in(l + 1, hi) % FULL;
        err_exp = aborted && (c > end_run);
        n_vec++;
        if (count !== CBITS'(cnt_exp)) begin
          n_err++;
          $display("FAIL %s count cyc=%0d got %0d expected %0d", name, c, count, cnt_exp);
        end
        n_vec++;
        if (error !== err_exp) begin
          n_err++;
          $display("FAIL %s error cyc=%0d got %b expected %b", name, c, error, err_exp);
        end
      end
      start  = (c == c0) || (stray_start && c == l + 2);
      frames = (c == c0) ? CBITS'(frames_v) : CBITS'($urandom);
      abort  = (abort_with_start && c == c0) || ((mode == 1 || mode == 2) && c == x) ||
               (drain_abort && c == end_run + 1);
      locked = (c >= l) && (c <= last_lock);
      @(negedge clk);
    end
    start  = 1'b0;
    abort  = 1'b0;
    locked = 1'b0;
  endtask

  task automatic test_lock_wait();
    int c0, a, ab, last_en;
    logic [3:0] got, exp;
    c0 = cyc;
    a  = next_strobe(c0 + 1);
`ifdef HILBERT_SEQ_TIMEOUT_EN
    ab      = -1;
    last_en = a + 4 * TICKS;
`else
    ab      = a + 1 + 10 * TICKS;
    last_en = ab;
`endif
    for (int c = c0; c <= last_en + 4; c++) begin
      exp = {(c >= c0 + 1) && (c <= last_en + 1), (c >= c0 + 1) && (c <= last_en),
             1'b0, (c % TICKS) == TICKS - 1};
      got = {busy, enable, done, strobe};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL lock_wait ctl cyc=%0d busy/en/done/stb got %b expected %b", c, got, exp);
      end
      if (c > c0) begin
        n_vec++;
        if (error !== (c > last_en)) begin
          n_err++;
          $display("FAIL lock_wait error cyc=%0d got %b expected %b", c, error, c > last_en);
        end
      end
      start  = (c == c0);
      frames = CBITS'(4);
      abort  = (c == ab);
      locked = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_idle_abort(input bit err_exp);
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if ({busy, enable, done, error} !== {3'b000, err_exp}) begin
        n_err++;
        $display("FAIL idle_abort busy/en/done/err got %b%b%b%b expected 000%b",
                 busy, enable, done, error, err_exp);
      end
      abort = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0, a, l;
    c0 = cyc;
    a  = next_strobe(c0 + 1);
    l  = a + 1;
    for (int c = c0; c <= l + 30; c++) begin
      start  = (c == c0);
      frames = CBITS'(5);
      locked = (c >= l);
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if ({busy, enable} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_mid pre busy/en got %b%b expected 11", busy, enable);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({enable, strobe, busy, done, error, count} !== '0) begin
      n_err++;
      $display("FAIL reset_mid async got en/stb/busy/done/err=%b%b%b%b%b count=%0d expected all 0",
               enable, strobe, busy, done, error, count);
    end
    locked = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({enable, busy, done, count} !== '0) begin
      n_err++;
      $display("FAIL reset_mid hold en/busy/done=%b%b%b count=%0d expected all 0",
               enable, busy, done, count);
    end
    rst_n = 1'b1;
    test_block("post_reset", 2, 1, 0, 0, 1'b0);
  endtask

  initial begin
    int fr, md;
    test_reset();
    test_block("frames3", 3, 0, 0, 0, 1'b0);
    test_idle_abort(1'b0);
    test_block("abort_run", 4, int'($urandom_range(0, 20)), 1, 1, 1'b0);
    test_idle_abort(1'b1);
    test_block("start_abort", int'($urandom_range(1, 6)), int'($urandom_range(0, 20)), 0, 0, 1'b1);
    test_block("term_abort", 3, int'($urandom_range(0, 20)), 2, 0, 1'b0);
    test_block("lock_drop", 5, int'($urandom_range(0, 20)), 3, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      fr = int'($urandom_range(2, 8));
      md = int'($urandom_range(0, 3));
      test_block("random", fr, int'($urandom_range(0, 30)), md,
                 int'($urandom_range(1, fr - 1)), $urandom_range(0, 1) == 1);
    end
    test_block("wrap", 0, 0, 0, 0, 1'b0);
    test_lock_wait();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
